wg_dispatcher: RTL and testbench

Kernel work-group dispatcher for the e-GPU compute units. On a kernel start it hands out work-group IDs 0..N-1 to compute units with a valid/ready handshake, in round-robin order, one per cycle. Each CU holds at most one work-group at a time. Once all IDs are issued, it sends each idle CU a one-cycle sleep request, which drives the CU power/clock controller's sleep inputs. It pulses done when every work-group has completed.

---
 rtl/wg_dispatcher_if.sv | 28 ++
 rtl/wg_dispatcher.sv | 158 +++++++++++++++
 tb/tb_wg_dispatcher.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wg_dispatcher_if.sv
// Dispatcher <-> compute-unit bundle: work-group offers, completions and sleep requests.
// The master side belongs to wg_dispatcher, the slave side to the compute-unit array.
interface wg_dispatcher_if #(
    parameter int NUM_CU = 4,
    parameter int WG_W   = 16
);
    logic [NUM_CU-1:0]      cu_ready_i;
    logic [NUM_CU-1:0]      cu_valid_o;
    logic [NUM_CU*WG_W-1:0] cu_wg_id_o;
    logic [NUM_CU-1:0]      cu_done_i;
    logic [NUM_CU-1:0]      cu_sleep_req_o;

    modport master (
        input  cu_ready_i,
        input  cu_done_i,
        output cu_valid_o,
        output cu_wg_id_o,
        output cu_sleep_req_o
    );

    modport slave (
        output cu_ready_i,
        output cu_done_i,
        input  cu_valid_o,
        input  cu_wg_id_o,
        input  cu_sleep_req_o
    );
endinterface

// File: rtl/wg_dispatcher.sv
// Kernel work-group dispatcher: round-robin hand-out of IDs 0..N-1, CU sleep requests, done pulse.
// Optional kernel cycle counter enabled by defining WG_DISPATCHER_PERF_EN.
module wg_dispatcher #(
    parameter int NUM_CU = 4,
    parameter int WG_W   = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [WG_W-1:0] num_wg_i,
    output logic            busy_o,
    output logic            done_o,
    wg_dispatcher_if.master cu
`ifdef WG_DISPATCHER_PERF_EN
    ,
    output logic [31:0]     kernel_cycles_o
`endif
);
    localparam int PTR_W = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t            state_r, state_nx_s;
    logic [WG_W-1:0]   total_r, next_id_r, next_id_inc_s;
    logic [WG_W:0]     completed_r, done_cnt_s;
    logic [PTR_W-1:0]  rr_ptr_r, grant_idx_s, rr_nx_s;
    logic [NUM_CU-1:0] cu_busy_r, sleep_sent_r;
    logic [NUM_CU-1:0] eligible_s, grant_s, done_hit_s, sleep_req_s;
    logic              fire_s, start_acc_s;

    assign start_acc_s   = (state_r == ST_IDLE) && start_i;
    assign eligible_s    = cu.cu_ready_i & ~cu_busy_r;
    assign done_hit_s    = cu.cu_done_i & cu_busy_r;
    assign fire_s        = |(grant_s & cu.cu_ready_i);
    assign next_id_inc_s = next_id_r + WG_W'(1);
    assign rr_nx_s       = (grant_idx_s == PTR_W'(NUM_CU - 1)) ? PTR_W'(0) : (grant_idx_s + PTR_W'(1));
    assign sleep_req_s   = (state_r == ST_DRAIN) ? (~cu_busy_r & ~sleep_sent_r) : {NUM_CU{1'b0}};

    // Round-robin grant: scanning downward lets the candidate closest to rr_ptr_r win
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        if (state_r == ST_DISPATCH) begin
            for (int i = NUM_CU - 1; i >= 0; i--) begin
                if (eligible_s[(int'(rr_ptr_r) + i) % NUM_CU]) begin
                    grant_idx_s = PTR_W'((int'(rr_ptr_r) + i) % NUM_CU);
                end else begin
                    grant_idx_s = grant_idx_s;
                end
            end
            grant_s[grant_idx_s] = eligible_s[grant_idx_s];
        end else begin
            grant_s     = '0;
            grant_idx_s = '0;
        end
    end

    // Number of genuine completions this cycle (dones from idle CUs are dropped)
    always_comb begin
        done_cnt_s = '0;
        for (int k = 0; k < NUM_CU; k++) begin
            done_cnt_s = done_cnt_s + (WG_W+1)'(done_hit_s[k]);
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_nx_s = (num_wg_i != '0) ? ST_DISPATCH : ST_DRAIN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (fire_s && (next_id_inc_s == total_r)) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_DISPATCH;
                end
            end
            ST_DRAIN: begin
                if ((completed_r == {1'b0, total_r}) && (&sleep_sent_r)) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Kernel bookkeeping; rr_ptr_r deliberately survives across kernels
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            total_r      <= '0;
            next_id_r    <= '0;
            completed_r  <= '0;
            rr_ptr_r     <= '0;
            cu_busy_r    <= '0;
            sleep_sent_r <= '0;
        end else if (start_acc_s) begin
            total_r      <= num_wg_i;
            next_id_r    <= '0;
            completed_r  <= '0;
            cu_busy_r    <= '0;
            sleep_sent_r <= '0;
        end else begin
            completed_r  <= completed_r + done_cnt_s;
            cu_busy_r    <= (cu_busy_r & ~done_hit_s) | grant_s;
            sleep_sent_r <= sleep_sent_r | sleep_req_s;
            if (fire_s) begin
                next_id_r <= next_id_inc_s;
                rr_ptr_r  <= rr_nx_s;
            end
        end
    end

    assign busy_o            = (state_r != ST_IDLE);
    assign done_o            = (state_r == ST_DONE);
    assign cu.cu_valid_o     = grant_s;
    assign cu.cu_wg_id_o     = {NUM_CU{next_id_r}};
    assign cu.cu_sleep_req_o = sleep_req_s;

`ifdef WG_DISPATCHER_PERF_EN
    logic [31:0] kernel_cycles_r;

    // Saturating count of non-IDLE cycles, held in IDLE until the next start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            kernel_cycles_r <= 32'd0;
        end else if (start_acc_s) begin
            kernel_cycles_r <= 32'd0;
        end else if ((state_r != ST_IDLE) && (kernel_cycles_r != 32'hFFFF_FFFF)) begin
            kernel_cycles_r <= kernel_cycles_r + 32'd1;
        end
    end

    assign kernel_cycles_o = kernel_cycles_r;
`endif
endmodule

// File: tb/tb_wg_dispatcher.sv
// Self-checking bench for wg_dispatcher: kernel vector table with a dispatch scoreboard,
// plus hand-written empty-kernel, concurrent-event, perf-counter and async-reset sequences.
module tb_wg_dispatcher;
    localparam int NUM_CU = 4;
    localparam int WG_W   = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            start_i;
    logic [WG_W-1:0] num_wg_i;
    logic            busy_o;
    logic            done_o;
`ifdef WG_DISPATCHER_PERF_EN
    logic [31:0]     kernel_cycles;
`endif

    always #5 clk_i = ~clk_i;

    wg_dispatcher_if #(.NUM_CU(NUM_CU), .WG_W(WG_W)) dif ();

    wg_dispatcher #(.NUM_CU(NUM_CU), .WG_W(WG_W)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .num_wg_i (num_wg_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .cu       (dif)
`ifdef WG_DISPATCHER_PERF_EN
        ,
        .kernel_cycles_o (kernel_cycles)
`endif
    );

    typedef struct {
        int          cu;
        logic [15:0] id;
    } disp_t;

    typedef struct {
        logic [15:0]     num_wg;
        logic [3:0]      ready;
        int              lat;
        logic [7:0][1:0] seq;   // expected CU for ID i in seq[i]
    } vec_t;

    disp_t exp_q[$];
    vec_t  vecs[5];
    int    n_tests = 0;
    int    n_fail  = 0;

    logic [NUM_CU-1:0]      s_valid, s_sleep;
    logic [NUM_CU*WG_W-1:0] s_ids;
    logic                   s_done, s_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive at posedge+1, sample at negedge, score any dispatch, return at next posedge+1.
    task automatic step(input logic st, input logic [15:0] nwg, input logic [3:0] rdy, input logic [3:0] dn);
        int    g;
        disp_t e;
        start_i        = st;
        num_wg_i       = nwg;
        dif.cu_ready_i = rdy;
        dif.cu_done_i  = dn;
        @(negedge clk_i);
        s_valid = dif.cu_valid_o;
        s_sleep = dif.cu_sleep_req_o;
        s_ids   = dif.cu_wg_id_o;
        s_done  = done_o;
        s_busy  = busy_o;
        if (s_valid != '0) begin
            chk("valid_onehot", $countones(s_valid), 1);
            g = 0;
            for (int k = 0; k < NUM_CU; k++) begin
                if (s_valid[k]) g = k;
            end
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_dispatch: actual cu=%0d id=%0h required none", g, s_ids[g*WG_W +: WG_W]);
            end else begin
                e = exp_q.pop_front();
                chk("dispatch_cu", g, e.cu);
                chk("dispatch_id", s_ids[g*WG_W +: WG_W], e.id);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    // Full kernel with CUs that return done 'lat' cycles after each fire.
    task automatic run_kernel(input logic [15:0] nwg, input logic [3:0] rdy, input int lat,
                              input logic [7:0][1:0] seq, output int busy_cycles);
        int         cd[NUM_CU];
        int         sleep_cnt[NUM_CU];
        int         sleep_cyc[NUM_CU];
        int         done_cnt, last_fire;
        bit         finished;
        logic [3:0] dn;
        for (int k = 0; k < NUM_CU; k++) begin
            cd[k] = 0; sleep_cnt[k] = 0; sleep_cyc[k] = -1;
        end
        for (int i = 0; i < int'(nwg); i++) exp_q.push_back('{cu: int'(seq[i]), id: 16'(i)});
        done_cnt = 0; last_fire = 0; busy_cycles = 0; finished = 1'b0;
        step(1'b1, nwg, rdy, 4'h0);
        for (int c = 1; c <= 200 && !finished; c++) begin
            dn = 4'h0;
            for (int k = 0; k < NUM_CU; k++) begin
                if (cd[k] > 0) begin
                    cd[k]--;
                    if (cd[k] == 0) dn[k] = 1'b1;
                end
            end
            step(1'b0, nwg, rdy, dn);
            for (int k = 0; k < NUM_CU; k++) begin
                if (s_valid[k]) begin cd[k] = lat; last_fire = c; end
                if (s_sleep[k]) begin
                    sleep_cnt[k]++;
                    if (sleep_cyc[k] < 0) sleep_cyc[k] = c;
                end
            end
            if (s_busy) busy_cycles++;
            if (done_cnt > 0) begin
                chk("busy_after_done", s_busy, 0);
                finished = 1'b1;
            end
            if (s_done) done_cnt++;
        end
        if (!finished) begin
            n_tests++; n_fail++;
            $display("FAIL kernel_timeout: actual done pulses=%0d required 1 within 200 cycles", done_cnt);
        end
        chk("done_pulses", done_cnt, 1);
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
        for (int k = 0; k < NUM_CU; k++) begin
            chk("sleep_pulses", sleep_cnt[k], 1);
            if (!rdy[k]) chk("unready_sleep_cycle", sleep_cyc[k], last_fire + 1);
        end
    endtask

    initial begin
        int         bc;
        logic [3:0] dn;
        logic [3:0] exp_sleep;

        vecs[0] = '{16'd8, 4'hF,    3, {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[1] = '{16'd6, 4'b1011, 3, {2'd0, 2'd0, 2'd3, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0}};
        vecs[2] = '{16'd3, 4'hF,    1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0}};
        vecs[3] = '{16'd5, 4'b0001, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[4] = '{16'd4, 4'b0110, 2, {2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1}};

        rst_ni = 1'b0; start_i = 1'b0; num_wg_i = '0;
        dif.cu_ready_i = '0; dif.cu_done_i = '0;
        #12;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_valid", dif.cu_valid_o, 0);
        chk("rst_sleep", dif.cu_sleep_req_o, 0);
        chk("rst_ids", dif.cu_wg_id_o[31:0], 0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Round-robin pointer carries across kernels, so row order matters
        for (int i = 0; i < 5; i++) begin
            run_kernel(vecs[i].num_wg, vecs[i].ready, vecs[i].lat, vecs[i].seq, bc);
        end

        // Empty kernel
        step(1'b1, 16'd0, 4'hF, 4'h0);
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 16'd0, 4'hF, 4'h0);
            chk("empty_sleep", s_sleep, (c == 1) ? 4'hF : 4'h0);
            chk("empty_done", s_done, (c == 3) ? 1 : 0);
            chk("empty_busy", s_busy, (c <= 3) ? 1 : 0);
        end

        // Spurious done, ignored start, done on CU1 together with fire on CU3 (rr_ptr starts at 3)
        exp_q.push_back('{cu: 3, id: 16'd0});
        exp_q.push_back('{cu: 1, id: 16'd1});
        exp_q.push_back('{cu: 3, id: 16'd2});
        exp_q.push_back('{cu: 1, id: 16'd3});
        for (int c = 0; c <= 12; c++) begin
            case (c)
                3:       dn = 4'b0001;
                4:       dn = 4'b1000;
                5:       dn = 4'b0010;
                8:       dn = 4'b1010;
                default: dn = 4'b0000;
            endcase
            step((c == 0) || (c == 3), (c == 3) ? 16'd9 : 16'd4, 4'b1010, dn);
            if (c >= 1) begin
                exp_sleep = (c == 7) ? 4'b0101 : ((c == 9) ? 4'b1010 : 4'b0000);
                chk("conc_sleep", s_sleep, exp_sleep);
                chk("conc_done", s_done, (c == 11) ? 1 : 0);
                chk("conc_busy", s_busy, (c <= 11) ? 1 : 0);
            end
        end
        chk("conc_queue_empty", exp_q.size(), 0);
        exp_q.delete();

`ifdef WG_DISPATCHER_PERF_EN
        run_kernel(16'd1, 4'hF, 2, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2}, bc);
        chk("perf_cycles", kernel_cycles, bc);
        for (int c = 0; c < 3; c++) step(1'b0, 16'd0, 4'hF, 4'h0);
        chk("perf_hold", kernel_cycles, bc);
`endif

        // Asynchronous reset in the middle of DISPATCH
        step(1'b1, 16'd8, 4'h0, 4'h0);
        step(1'b0, 16'd8, 4'h0, 4'h0);
        chk("mid_busy_before_rst", s_busy, 1);
        dif.cu_ready_i = 4'hF;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_valid", dif.cu_valid_o, 0);
        chk("mid_rst_sleep", dif.cu_sleep_req_o, 0);
        chk("mid_rst_ids", dif.cu_wg_id_o[31:0], 0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run_kernel(16'd2, 4'hF, 2, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0}, bc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
